// File: rtl/blockram_memu_pkg.sv
// blockram_memu_pkg: shared base address, response type and window check for the memu
package blockram_memu_pkg;
  localparam logic [31:0] BASE_ADDR = 32'h1000_0000;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  // word-aligned and inside [base, base + 4*words), widened so the top never wraps
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base, input logic [31:0] words);
    logic [33:0] a, lo, hi;
    a  = {2'b00, addr};
    lo = {2'b00, base};
    hi = lo + {words, 2'b00};
    return addr[1:0] == 2'b00 && a >= lo && a < hi;
  endfunction
endpackage

// File: rtl/blockram_memu_initiator_fifo.sv
// memu_rsp_fifo: in-order response queue whose outputs hold the last popped entry when empty
module memu_rsp_fifo
  import blockram_memu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  rsp_t          din,
  output rsp_t          dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  rsp_t mem [DEPTH];
  rsp_t last;
  logic [PW-1:0] rptr, wptr;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout  = empty ? last : mem[rptr];
  // storage, pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      last  <= '0;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      end
      if (pop) begin
        last <= mem[rptr];
        rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/blockram_memu_initiator.sv
// blockram_memu_initiator: core-side requester driving one block-RAM port with in-order responses
module blockram_memu_initiator
  import blockram_memu_pkg::rsp_t;
  import blockram_memu_pkg::in_window;
#(
  parameter logic [31:0] BASE_ADDR = blockram_memu_pkg::BASE_ADDR,
  parameter int unsigned RAM_SIZE  = 16384,
  parameter int          RSP_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_bsel,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bram_en,
  output logic [3:0]  bram_we,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_di,
  input  logic [31:0] bram_do
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  logic acc, ok, pop, push, full, empty;
  logic s1_valid, s1_we, s1_err;
  logic [CW-1:0] cnt;
  rsp_t din, dout;
  assign ok        = in_window(req_addr, BASE_ADDR, 32'(RAM_SIZE));
  assign pop       = !empty && rsp_ready;
  assign req_ready = !reset && (int'(cnt) + int'(s1_valid) - int'(pop) < RSP_DEPTH);
  assign acc       = req_valid && req_ready;
  assign bram_en   = acc && ok;
  assign bram_we   = (bram_en && req_we) ? req_bsel : 4'h0;
  assign bram_addr = acc ? {2'b00, req_addr[31:2]} : 32'h0;
  assign bram_di   = acc ? req_wdata : 32'h0;
  assign push      = s1_valid && !full;
  assign din       = {(!s1_we && !s1_err) ? bram_do : 32'h0, s1_err};
  assign rsp_valid = !empty;
  assign rsp_rdata = dout.rdata;
  assign rsp_err   = dout.err;
  // stage 1 tracks the request whose RAM data arrives this cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_we    <= 1'b0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= acc;
      s1_we    <= req_we;
      s1_err   <= !ok;
    end
  end
  memu_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
    .dout(dout), .full(full), .empty(empty), .count(cnt)
  );
endmodule

// File: tb/tb_blockram_memu_initiator.sv
// tb_blockram_memu_initiator: scoreboard bench with a 1-cycle memu RAM model and a word-array reference
module tb_blockram_memu_initiator;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int WORDS = 16384;
  localparam int DEPTH = 3;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_ready, req_we = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_bsel = 0;
  logic rsp_valid, rsp_ready = 0, rsp_err;
  logic [31:0] rsp_rdata;
  logic bram_en;
  logic [3:0] bram_we;
  logic [31:0] bram_addr, bram_di, bram_do = 0;
  always #5 clk = ~clk;

  blockram_memu_initiator #(.BASE_ADDR(BASE), .RAM_SIZE(WORDS), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_bsel(req_bsel), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .bram_en(bram_en),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_di(bram_di), .bram_do(bram_do)
  );

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  logic [31:0] ram [WORDS];
  logic [31:0] ref_mem [WORDS];
  exp_t sb[$];
  int pop_cyc[$];
  int checks = 0, failures = 0, cyc = 0, err_pops = 0, idx;
  bit rnd_mode = 0, gap_track = 0, hold_v = 0, acc, okm;
  logic [31:0] hold_d, last_rdata = 0;
  logic hold_e;
  exp_t e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit ok_addr(input logic [31:0] a);
    longint x = longint'(a);
    return (x % 4 == 0) && x >= longint'(BASE) && x < longint'(BASE) + 4 * WORDS;
  endfunction

  // memu RAM model: read-first, one cycle latency, per-byte writes
  always @(posedge clk) if (bram_en) begin
    idx = int'(bram_addr - (BASE >> 2));
    if (idx >= 0 && idx < WORDS) begin
      bram_do <= ram[idx];
      for (int b = 0; b < 4; b++) if (bram_we[b]) ram[idx][8*b +: 8] <= bram_di[8*b +: 8];
    end
  end

  // random response back-pressure during the random phase
  initial forever begin
    @(posedge clk); #1;
    if (rnd_mode) rsp_ready = $urandom_range(0, 3) != 0;
  end

  // monitor: RAM-port checks and scoreboard push on acceptance, compare on pop
  always @(negedge clk) begin
    cyc++;
    acc = req_valid && req_ready;
    okm = ok_addr(req_addr);
    chk("bram_en", bram_en, acc && okm);
    chk("bram_we", bram_we, (acc && okm && req_we) ? req_bsel : 4'h0);
    if (acc && okm) begin
      chk("bram_addr", bram_addr, req_addr >> 2);
      chk("bram_di", bram_di, req_wdata);
    end
    if (reset) begin
      sb.delete();
      hold_v = 0;
    end else begin
      if (acc) begin
        idx = int'((req_addr - BASE) >> 2);
        e.err = !okm;
        e.rdata = (okm && !req_we) ? ref_mem[idx] : 32'h0;
        sb.push_back(e);
        if (okm && req_we)
          for (int b = 0; b < 4; b++) if (req_bsel[b]) ref_mem[idx][8*b +: 8] = req_wdata[8*b +: 8];
      end
      if (hold_v) chk("rsp_stable", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, hold_e, hold_d});
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rsp: got rdata=%0h err=%0b expected none", rsp_rdata, rsp_err);
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", rsp_err, e.err);
        end
        last_rdata = rsp_rdata;
        if (rsp_err) err_pops++;
        if (gap_track) pop_cyc.push_back(cyc);
      end
      hold_v = rsp_valid && !rsp_ready;
      hold_d = rsp_rdata;
      hold_e = rsp_err;
    end
  end

  task automatic issue(input bit we, input logic [31:0] a, input logic [3:0] bs, input logic [31:0] wd, output int stalls);
    req_valid = 1; req_we = we; req_addr = a; req_bsel = bs; req_wdata = wd; stalls = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      stalls++;
      if (stalls > 300) begin
        checks++; failures++;
        $display("FAIL issue_timeout: addr %0h not accepted in 300 cycles", a);
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin @(posedge clk); n++; end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st, tot, n, e0;
    logic [31:0] a;
    logic [31:0] bad [4];
    bit got;
    bad[0] = 32'h0FFF_FFFC; bad[1] = 32'h1000_0002; bad[2] = BASE + 4 * WORDS; bad[3] = 32'hFFFF_FFFC;
    for (int i = 0; i < WORDS; i++) begin
      ram[i] = (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
      ref_mem[i] = ram[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    chk("reset_bram_ctl", {bram_en, bram_we}, 0);
    chk("reset_bram_addr", bram_addr, 0);
    chk("reset_bram_di", bram_di, 0);
    @(posedge clk); #1;
    reset = 0; rsp_ready = 1;
    // full-word write then read back
    issue(1, 32'h1000_0010, 4'hF, 32'hDEAD_BEEF, st);
    issue(0, 32'h1000_0010, 4'h0, 32'h0, st);
    drain();
    chk("t1_readback", last_rdata, 32'hDEAD_BEEF);
    // single-lane write
    issue(1, 32'h1000_0010, 4'b0010, 32'h0000_AB00, st);
    issue(0, 32'h1000_0010, 4'h0, 32'h0, st);
    drain();
    chk("t2_byte1", last_rdata, 32'hDEAD_ABEF);
    // back-to-back reads at full throughput
    gap_track = 1; pop_cyc.delete(); tot = 0;
    for (int i = 0; i < 8; i++) begin
      issue(0, BASE + 32'h100 + 4 * i, 4'h0, 32'h0, st);
      tot += st;
    end
    drain();
    gap_track = 0;
    chk("t3_stalls", tot, 0);
    chk("t3_pops", pop_cyc.size(), 8);
    for (int i = 1; i < pop_cyc.size(); i++) chk("t3_gap", pop_cyc[i] - pop_cyc[i-1], 1);
    // back-pressure: exactly DEPTH accepted
    rsp_ready = 0; n = 0; a = BASE + 32'h200;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1; req_we = 0; req_addr = a;
      @(negedge clk);
      got = req_ready;
      if (got) n++;
      @(posedge clk); #1;
      if (got) a += 4;
    end
    req_valid = 0;
    #1;
    chk("t4_accepted", n, DEPTH);
    chk("t4_ready_low", req_ready, 0);
    rsp_ready = 1;
    drain();
    // bad addresses interleaved with valid reads
    e0 = err_pops;
    for (int i = 0; i < 4; i++) begin
      issue(0, BASE + 32'h300 + 4 * i, 4'h0, 32'h0, st);
      issue(i[0], bad[i], 4'hF, 32'h1234_5678, st);
    end
    drain();
    chk("t5_err_count", err_pops - e0, 4);
    // reset with 2 queued and 1 in flight
    rsp_ready = 0; tot = 0;
    for (int i = 0; i < 3; i++) begin
      issue(0, BASE + 32'h400 + 4 * i, 4'h0, 32'h0, st);
      tot += st;
    end
    chk("t6_fill_stalls", tot, 0);
    reset = 1;
    @(posedge clk); @(negedge clk);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_req_ready", req_ready, 0);
    @(posedge clk); #1;
    reset = 0; rsp_ready = 1;
    issue(0, 32'h1000_0010, 4'h0, 32'h0, st);
    drain();
    chk("t6_fresh_read", last_rdata, 32'hDEAD_ABEF);
    // randomized traffic
    rnd_mode = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0: a = bad[$urandom_range(0, 3)];
        1: a = BASE + 4 * (WORDS - 1 - $urandom_range(0, 3));
        default: a = BASE + 4 * $urandom_range(0, 63);
      endcase
      issue($urandom_range(0, 1), a, 4'($urandom), $urandom, st);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    rnd_mode = 0;
    @(posedge clk); #2;
    rsp_ready = 1;
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
